// File: rtl/dec_bus_pkg.sv
// Shared types and default sizes for the arbitrated line-decoder bus.
package dec_bus_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} dec_bus_state_t;
  localparam int DEC_AW = 5;
  localparam int DEC_DW = 32;
endpackage

// File: rtl/dec_line_decoder.sv
// Enable-gated AW-to-DW one-hot line decoder, purely combinational.
module dec_line_decoder #(
  parameter int AW = dec_bus_pkg::DEC_AW,
  parameter int DW = dec_bus_pkg::DEC_DW
) (
  input  logic [AW-1:0] addr_i,
  input  logic          en_i,
  output logic [DW-1:0] dec_o
);
  for (genvar i = 0; i < DW; i++) begin : g_line
    assign dec_o[i] = en_i && (addr_i == AW'(i));
  end
endmodule

// File: rtl/dec_bus_arbiter.sv
// Round-robin arbiter granting one requester at a time a HOLD-cycle window
// on a shared enable-gated line decoder, followed by one idle gap cycle.
module dec_bus_arbiter
  import dec_bus_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = DEC_AW,
  parameter int DW   = DEC_DW,
  parameter int HOLD = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*AW-1:0] addr_i,
  output logic [NREQ-1:0]    grant_o,
  output logic [NREQ-1:0]    ack_o,
  output logic [AW-1:0]      addr_o,
  output logic               en_o,
  output logic [DW-1:0]      dec_o,
  output logic               busy_o
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  dec_bus_state_t  state_q;
  logic [NREQ-1:0] grant_q, ack_q;
  logic [AW-1:0]   addr_q;
  logic            en_q, busy_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [CW-1:0]   cnt_q;

  logic            win_found;
  logic [PW-1:0]   win_idx, cand;
  logic [PW-1:0]   rr_ptr_d;
  logic [NREQ-1:0] grant_d;
  logic [AW-1:0]   addr_d;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'((int'(rr_ptr_q) + k) % NREQ);
      if (req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_d  = '0;
    grant_d[win_idx] = 1'b1;
    addr_d   = addr_i[int'(win_idx)*AW +: AW];
    rr_ptr_d = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ack_q    <= '0;
      addr_q   <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: if (win_found) begin
          state_q  <= DRIVE;
          grant_q  <= grant_d;
          addr_q   <= addr_d;
          en_q     <= 1'b1;
          busy_q   <= 1'b1;
          cnt_q    <= CW'(HOLD - 1);
          rr_ptr_q <= rr_ptr_d;
          if (HOLD == 1) ack_q <= grant_d;
        end
        DRIVE: begin
          if (cnt_q == '0) begin
            state_q <= GAP;
            grant_q <= '0;
            en_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            // ack registered one edge early so it lands on the last DRIVE cycle
            if (cnt_q == CW'(1)) ack_q <= grant_q;
          end
        end
        GAP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o = grant_q;
  assign ack_o   = ack_q;
  assign addr_o  = addr_q;
  assign en_o    = en_q;
  assign busy_o  = busy_q;

  dec_line_decoder #(.AW(AW), .DW(DW)) u_dec (
    .addr_i (addr_q),
    .en_i   (en_q),
    .dec_o  (dec_o)
  );
endmodule
